// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the MEM stage and data memory.
//
// Stores (word address, lane-aligned data, byte enables) are queued in a
// DEPTH-entry FIFO and drained oldest-first over a mem_req/mem_ack handshake.
// Loads probe the buffer combinationally: each needed byte lane is taken from
// the youngest matching entry. Full coverage -> ld_hit, partial -> ld_stall.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   st_valid/st_addr/st_wdata/st_be -> st_ready    store push
//   ld_valid/ld_addr/ld_be -> ld_hit/ld_data/ld_stall  load probe (comb)
//   mem_req/mem_addr/mem_wdata/mem_be <- mem_ack    head drain
//   count, empty                 occupancy
//
// Build option: define STORE_BUFFER_MERGE_EN to coalesce a store into the
// youngest entry (when it is not the head and no pop is happening) instead
// of allocating a new one.

// Per-byte-lane forwarding: picks the youngest hitting entry for one lane.
// hit/bytes are ordered by age, index 0 = oldest.
module store_buffer_lane #(
  parameter int DEPTH = 4
) (
  input  logic                  need,
  input  logic [DEPTH-1:0]      hit,
  input  logic [DEPTH-1:0][7:0] bytes,
  output logic                  found,
  output logic [7:0]            data
);
  always_comb begin
    found = 1'b0;
    data  = '0;
    if (need) begin
      // Later (younger) hits overwrite earlier ones.
      for (int k = 0; k < DEPTH; k++) begin
        if (hit[k]) begin
          found = 1'b1;
          data  = bytes[k];
        end
      end
    end
  end
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_wdata,
  input  logic [3:0]    st_be,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [3:0]    ld_be,
  output logic          ld_hit,
  output logic [31:0]   ld_data,
  output logic          ld_stall,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW        = $clog2(DEPTH);
  localparam int NUM_LANES = 4;

  logic [29:0]   e_addr [DEPTH];
  logic [31:0]   e_data [DEPTH];
  logic [3:0]    e_be   [DEPTH];

  logic [PW-1:0] head, tail, tail_m1;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          full, pop, push, merge, st_ok;
  logic [29:0]   st_word, ld_word;
  logic          unused_addr_lsb;

  assign st_word         = st_addr[31:2];
  assign ld_word         = ld_addr[31:2];
  assign unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0]};

  assign tail_m1 = tail - PW'(1);
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign st_ok   = st_valid && (st_be != 4'd0);

  // ---------------------------------------------------------------- drain
  assign mem_req   = !empty;
  assign mem_addr  = {e_addr[head], 2'b00};
  assign mem_wdata = e_data[head];
  assign mem_be    = e_be[head];
  assign pop       = mem_req && mem_ack;

  // ---------------------------------------------------------------- accept
`ifdef STORE_BUFFER_MERGE_EN
  // Merge only into the youngest entry, never the head (it may be on the bus),
  // and never while a pop moves the head underneath us.
  assign merge    = st_ok && (cnt >= CW'(2)) && !pop && (e_addr[tail_m1] == st_word);
  assign st_ready = !full || merge;
`else
  assign merge    = 1'b0;
  assign st_ready = !full;
`endif

  // A pop never frees space for a same-cycle push: st_ready depends on count only.
  assign push = st_ok && st_ready && !merge;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!push && pop) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        e_addr[k] <= '0;
        e_data[k] <= '0;
        e_be[k]   <= '0;
      end
    end else begin
      if (push) begin
        e_addr[tail] <= st_word;
        e_data[tail] <= st_wdata;
        e_be[tail]   <= st_be;
      end
      if (merge) begin
        e_be[tail_m1] <= e_be[tail_m1] | st_be;
        for (int i = 0; i < NUM_LANES; i++)
          if (st_be[i]) e_data[tail_m1][8*i +: 8] <= st_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- probe
  // Re-order entries by age (0 = head/oldest) so the lane pick is a simple
  // "last hit wins" scan. Only occupied slots can match.
  logic [PW-1:0]                          age_idx [DEPTH];
  logic [DEPTH-1:0]                       age_match;
  logic [NUM_LANES-1:0][DEPTH-1:0]        lane_hit;
  logic [NUM_LANES-1:0][DEPTH-1:0][7:0]   lane_bytes;
  logic [NUM_LANES-1:0]                   lane_need, lane_found;
  logic                                   any_found, all_found;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign age_idx[k]   = head + PW'(k);
      assign age_match[k] = (CW'(k) < cnt) && (e_addr[age_idx[k]] == ld_word);
    end
  endgenerate

  always_comb begin
    lane_hit   = '0;
    lane_bytes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        lane_hit[i][k]   = age_match[k] & e_be[age_idx[k]][i];
        lane_bytes[i][k] = e_data[age_idx[k]][8*i +: 8];
      end
    end
  end

  assign lane_need = {NUM_LANES{ld_valid}} & ld_be;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      store_buffer_lane #(.DEPTH(DEPTH)) u_lane (
        .need  (lane_need[i]),
        .hit   (lane_hit[i]),
        .bytes (lane_bytes[i]),
        .found (lane_found[i]),
        .data  (ld_data[8*i +: 8])
      );
    end
  endgenerate

  assign any_found = |lane_found;
  assign all_found = ((lane_found & lane_need) == lane_need);
  assign ld_hit    = any_found && all_found;
  assign ld_stall  = any_found && !all_found;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef STORE_BUFFER_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic [31:0]   st_addr, st_wdata;
  logic [3:0]    st_be;
  logic          st_ready;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [3:0]    ld_be;
  logic          ld_hit, ld_stall;
  logic [31:0]   ld_data;
  logic          mem_req;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [CW-1:0] count;
  logic          empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_be = '0;
    mem_ack  = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    st_valid = 1'b1; st_addr = a; st_wdata = d; st_be = b;
    tick();
    st_valid = 1'b0; st_be = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
    checks++; if (st_ready !== 1'b1)  begin errors++; $display("FAIL reset_st_ready got=%b want=1", st_ready); end
    checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
    checks++; if (mem_be !== 4'h0)    begin errors++; $display("FAIL reset_mem_be got=%h want=0", mem_be); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_drain;
    do_reset();
    push(32'h100, 32'hAABBCCDD, 4'hF);
    checks++; if (mem_req !== 1'b1)          begin errors++; $display("FAIL drain_req got=%b want=1", mem_req); end
    checks++; if (mem_addr !== 32'h100)      begin errors++; $display("FAIL drain_addr got=%h want=100", mem_addr); end
    checks++; if (mem_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL drain_wdata got=%h want=aabbccdd", mem_wdata); end
    checks++; if (mem_be !== 4'hF)           begin errors++; $display("FAIL drain_be got=%h want=f", mem_be); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL drain_hold req=%b addr=%h want 1/100", mem_req, mem_addr); end
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL drain_empty got=%b want=1", empty); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_req_low got=%b want=0", mem_req); end
  endtask

  task automatic test_full_wrap;
    do_reset();
    for (int k = 0; k < 4; k++) push(32'h10 * (k + 1), 32'hA000 + k, 4'hF);
    checks++; if (count !== 3'd4)    begin errors++; $display("FAIL full_count got=%0d want=4", count); end
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", st_ready); end
    push(32'h50, 32'h5555, 4'hF);
    checks++; if (count !== 3'd4)    begin errors++; $display("FAIL full_reject got=%0d want=4", count); end
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem_addr !== 32'h10 * (k + 1)) begin errors++; $display("FAIL wrap_order%0d got=%h want=%h", k, mem_addr, 32'h10 * (k + 1)); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b want=1", empty); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ack_when_empty got=%0d want=0", count); end
    mem_ack = 1'b0;
    push(32'h60, 32'h6666, 4'h3);
    checks++; if (mem_addr !== 32'h60 || mem_be !== 4'h3) begin errors++; $display("FAIL wrap_reuse addr=%h be=%h want 60/3", mem_addr, mem_be); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count got=%0d want=1", count); end
  endtask

  task automatic test_forward;
    do_reset();
    push(32'h200, 32'h000000EF, 4'b0001);
    push(32'h200, 32'h0000AB00, 4'b0010);
    ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'b0011; #1;
    checks++; if (ld_hit !== 1'b1 || ld_stall !== 1'b0) begin errors++; $display("FAIL fwd_hit hit=%b stall=%b want 1/0", ld_hit, ld_stall); end
    checks++; if (ld_data !== 32'h0000ABEF) begin errors++; $display("FAIL fwd_data got=%h want=0000abef", ld_data); end
    ld_be = 4'hF; #1;
    checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b1) begin errors++; $display("FAIL fwd_partial hit=%b stall=%b want 0/1", ld_hit, ld_stall); end
    ld_addr = 32'h204; #1;
    checks++; if (ld_hit !== 1'b0 || ld_stall !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL fwd_miss hit=%b stall=%b data=%h want 0/0/0", ld_hit, ld_stall, ld_data); end
    st_valid = 1'b1; st_addr = 32'h204; st_wdata = 32'h12345678; st_be = 4'hF; #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got=%b want=0", ld_hit); end
    tick();
    st_valid = 1'b0; st_be = '0;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h12345678) begin errors++; $display("FAIL fwd_next_cycle hit=%b data=%h want 1/12345678", ld_hit, ld_data); end
    ld_valid = 1'b0; #1;
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL fwd_invalid hit=%b data=%h want 0/0", ld_hit, ld_data); end
  endtask

  task automatic test_youngest;
    do_reset();
    push(32'h300, 32'h11111111, 4'hF);
    push(32'h300, 32'h22222222, 4'hF);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_be = 4'hF; #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h22222222) begin errors++; $display("FAIL youngest hit=%b data=%h want 1/22222222", ld_hit, ld_data); end
    ld_valid = 1'b0;
  endtask

  task automatic test_full_ack;
    do_reset();
    for (int k = 0; k < 4; k++) push(32'h10 * (k + 1), 32'hB000 + k, 4'hF);
    mem_ack = 1'b1;
    st_valid = 1'b1; st_addr = 32'h700; st_wdata = 32'h77777777; st_be = 4'hF; #1;
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fullack_ready got=%b want=0", st_ready); end
    tick();
    mem_ack = 1'b0; st_valid = 1'b0; st_be = '0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullack_count got=%0d want=3", count); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL fullack_head got=%h want=20", mem_addr); end
    ld_valid = 1'b1; ld_addr = 32'h700; ld_be = 4'hF; #1;
    checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fullack_dropped got=%b want=0", ld_hit); end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    push(32'h80, 32'h8, 4'hF);
    push(32'h84, 32'h9, 4'hF);
    mem_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || mem_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL midreset count=%0d req=%b empty=%b want 0/0/1", count, mem_req, empty); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL midreset_addr got=%h want=0", mem_addr); end
    tick();
    mem_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_merge;
    logic [2:0] exp_c;
    logic [3:0] exp_be;
    exp_c  = MERGE ? 3'd3 : 3'd4;
    exp_be = MERGE ? 4'b1001 : 4'b0001;
    do_reset();
    push(32'h10, 32'h1, 4'hF);
    push(32'h20, 32'h2, 4'hF);
    push(32'h400, 32'h000000AA, 4'b0001);
    push(32'h400, 32'hBB000000, 4'b1000);
    checks++; if (count !== exp_c) begin errors++; $display("FAIL merge_count got=%0d want=%0d", count, exp_c); end
    ld_valid = 1'b1; ld_addr = 32'h400; ld_be = 4'b1001; #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hBB0000AA) begin errors++; $display("FAIL merge_fwd hit=%b data=%h want 1/bb0000aa", ld_hit, ld_data); end
    ld_valid = 1'b0;
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    checks++; if (mem_addr !== 32'h400 || mem_be !== exp_be) begin errors++; $display("FAIL merge_be addr=%h be=%h want 400/%h", mem_addr, mem_be, exp_be); end
  endtask

  task automatic test_random;
    ent_t        q[$];
    ent_t        t;
    logic        v, ack, lv, pop_e, mrg, rdy, need, fnd, any_f, all_f;
    logic [31:0] a, d, la, exp_d, dmask;
    logic [3:0]  b, lb;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      a   = 32'h100 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      d   = $urandom;
      b   = 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 2) == 0);
      lv  = ($urandom_range(0, 3) != 0);
      la  = 32'h100 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      lb  = 4'($urandom_range(1, 15));
      st_valid = v; st_addr = a; st_wdata = d; st_be = b;
      mem_ack = ack; ld_valid = lv; ld_addr = la; ld_be = lb;
      #2;
      pop_e = ack && (q.size() != 0);
      mrg   = MERGE && v && (b != 4'd0) && (q.size() >= 2) && !pop_e && (q[q.size()-1].word == a[31:2]);
      rdy   = (q.size() < DEPTH) || mrg;
      checks++; if (st_ready !== rdy) begin errors++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, st_ready, rdy); end
      checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, q.size()); end
      checks++; if (mem_req !== (q.size() != 0) || empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_req c=%0d req=%b empty=%b size=%0d", c, mem_req, empty, q.size()); end
      if (q.size() != 0) begin
        checks++;
        if (mem_addr !== {q[0].word, 2'b00} || mem_wdata !== q[0].data || mem_be !== q[0].be) begin
          errors++; $display("FAIL rnd_head c=%0d got=%h/%h/%h want=%h/%h/%h", c, mem_addr, mem_wdata, mem_be, {q[0].word, 2'b00}, q[0].data, q[0].be);
        end
      end
      exp_d = '0; dmask = '0; any_f = 1'b0; all_f = 1'b1;
      for (int i = 0; i < 4; i++) begin
        need = lv && lb[i];
        fnd  = 1'b0;
        if (need) begin
          for (int j = q.size() - 1; j >= 0; j--) begin
            if (!fnd && q[j].word == la[31:2] && q[j].be[i]) begin
              fnd = 1'b1;
              exp_d[8*i +: 8] = q[j].data[8*i +: 8];
            end
          end
        end
        if (!need || fnd) dmask[8*i +: 8] = 8'hFF;
        if (fnd) any_f = 1'b1;
        if (need && !fnd) all_f = 1'b0;
      end
      checks++; if (ld_hit !== (any_f && all_f) || ld_stall !== (any_f && !all_f)) begin errors++; $display("FAIL rnd_probe c=%0d hit=%b stall=%b want %b/%b", c, ld_hit, ld_stall, any_f && all_f, any_f && !all_f); end
      checks++; if ((ld_data & dmask) !== exp_d) begin errors++; $display("FAIL rnd_ld_data c=%0d got=%h want=%h mask=%h", c, ld_data, exp_d, dmask); end
      tick();
      if (pop_e) void'(q.pop_front());
      if (mrg) begin
        t = q[q.size()-1];
        t.be = t.be | b;
        for (int i = 0; i < 4; i++) if (b[i]) t.data[8*i +: 8] = d[8*i +: 8];
        q[q.size()-1] = t;
      end else if (v && rdy && b != 4'd0) begin
        t.word = a[31:2]; t.data = d; t.be = b;
        q.push_back(t);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_full_wrap();
    test_forward();
    test_youngest();
    test_full_ack();
    test_reset_mid_drain();
    test_merge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
